// File: rtl/vuvxu_banked8_seq.sv
// Issue sequencer for bank 0 of the 8-bank vector unit: splits one vector
// instruction into per-stripe read/ALU commands and delayed write commands.
module vuvxu_banked8_seq #(
  parameter int NBANK = 8,
  parameter int REGW  = 8,
  parameter int VLENW = 11,
  parameter int FNW   = 11,
  parameter int DATAW = 65,
  parameter int OPLW  = 2,
  parameter int RPW   = 8,
  parameter int WPW   = 3,
  parameter int WLAT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [VLENW-1:0] in_vlen,
  input  logic [REGW-1:0]  in_rs,
  input  logic [REGW-1:0]  in_rd,
  input  logic [OPLW-1:0]  in_oplen,
  input  logic [RPW-1:0]   in_blen,
  input  logic [WPW-1:0]   in_wsel,
  input  logic             in_viu,
  input  logic [FNW-1:0]   in_fn,
  input  logic [DATAW-1:0] in_imm,
  output logic             seq_ren,
  output logic             seq_rlast,
  output logic [2:0]       seq_rcnt,
  output logic [REGW-1:0]  seq_raddr,
  output logic [OPLW-1:0]  seq_roplen,
  output logic [RPW-1:0]   seq_rblen,
  output logic             seq_viu_val,
  output logic [FNW-1:0]   seq_viu_fn,
  output logic [VLENW-1:0] seq_viu_utidx,
  output logic [DATAW-1:0] seq_viu_imm,
  output logic             seq_wen,
  output logic             seq_wlast,
  output logic [2:0]       seq_wcnt,
  output logic [REGW-1:0]  seq_waddr,
  output logic [WPW-1:0]   seq_wsel,
  output logic             done
);

  localparam int BSH = $clog2(NBANK);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    logic            en;
    logic            last;
    logic [2:0]      cnt;
    logic [REGW-1:0] addr;
  } wcmd_t;

  state_t state, state_nxt;

  logic             accept;
  logic [VLENW-1:0] rem, k;
  logic [REGW-1:0]  rs_q, rd_q, waddr_q;
  logic             viu_q;
  logic [FNW-1:0]   fn_q;
  logic [DATAW-1:0] imm_q;
  logic [OPLW-1:0]  oplen_q;
  logic [RPW-1:0]   blen_q;
  logic [WPW-1:0]   wsel_q;

  logic             issue;
  logic [VLENW-1:0] cur_rem, cur_k, take;
  logic [REGW-1:0]  cur_rs, cur_rd;
  logic             cur_viu;
  logic             stripe_last;

  wcmd_t wsrc, done_src;
  wcmd_t wpipe [WLAT];

  assign accept = in_val && in_rdy;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no latch is inferred on any path.
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (in_vlen == '0) ? S_DRAIN : S_ISSUE;
      S_ISSUE: if (seq_rlast) state_nxt = S_DRAIN;
      S_DRAIN: if (done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_rdy = (state == S_IDLE);
  end

  // Stripe 0 is computed straight from the inputs so it is registered on the
  // accept edge; later stripes come from the remaining-count/index registers.
  always_comb begin
    cur_rem = rem;
    cur_k   = k;
    cur_rs  = rs_q;
    cur_rd  = rd_q;
    cur_viu = viu_q;
    if (state == S_IDLE) begin
      cur_rem = in_vlen;
      cur_k   = '0;
      cur_rs  = in_rs;
      cur_rd  = in_rd;
      cur_viu = in_viu;
    end
    issue       = (state == S_IDLE) ? (accept && in_vlen != '0)
                                    : (state == S_ISSUE && !seq_rlast);
    stripe_last = (cur_rem <= VLENW'(NBANK));
    take        = stripe_last ? cur_rem : VLENW'(NBANK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q    <= '0;
      rd_q    <= '0;
      viu_q   <= 1'b0;
      fn_q    <= '0;
      imm_q   <= '0;
      oplen_q <= '0;
      blen_q  <= '0;
      wsel_q  <= '0;
    end else if (accept) begin
      rs_q    <= in_rs;
      rd_q    <= in_rd;
      viu_q   <= in_viu;
      fn_q    <= in_fn;
      imm_q   <= in_imm;
      oplen_q <= in_oplen;
      blen_q  <= in_blen;
      wsel_q  <= in_wsel;
    end
  end

  // Read/ALU command stage; waddr_q travels with it into the write pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem           <= '0;
      k             <= '0;
      seq_ren       <= 1'b0;
      seq_rlast     <= 1'b0;
      seq_rcnt      <= '0;
      seq_raddr     <= '0;
      seq_viu_val   <= 1'b0;
      seq_viu_utidx <= '0;
      waddr_q       <= '0;
    end else if (issue) begin
      rem           <= cur_rem - take;
      k             <= cur_k + VLENW'(1);
      seq_ren       <= 1'b1;
      seq_rlast     <= stripe_last;
      seq_rcnt      <= 3'(take - VLENW'(1));
      seq_raddr     <= cur_rs + cur_k[REGW-1:0];
      seq_viu_val   <= cur_viu;
      seq_viu_utidx <= cur_k << BSH;
      waddr_q       <= cur_rd + cur_k[REGW-1:0];
    end else begin
      seq_ren     <= 1'b0;
      seq_rlast   <= 1'b0;
      seq_viu_val <= 1'b0;
    end
  end

  assign wsrc = '{en: seq_ren, last: seq_rlast, cnt: seq_rcnt, addr: waddr_q};

  // Write command delay line; the tail entry drives the seq_w* outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the delay line is reset so writes of an interrupted instruction are dropped.
      for (int i = 0; i < WLAT; i++) wpipe[i] <= '0;
    end else begin
      wpipe[0] <= wsrc;
      for (int i = 1; i < WLAT; i++) wpipe[i] <= wpipe[i-1];
    end
  end

  // done is registered, so it looks one stage ahead of the write outputs.
  generate
    if (WLAT == 1) begin : g_done_lat1
      assign done_src = wsrc;
    end else begin : g_done_latn
      assign done_src = wpipe[WLAT-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (accept && in_vlen == '0) || (done_src.en && done_src.last);
  end

  assign seq_wen     = wpipe[WLAT-1].en;
  assign seq_wlast   = wpipe[WLAT-1].last;
  assign seq_wcnt    = wpipe[WLAT-1].cnt;
  assign seq_waddr   = wpipe[WLAT-1].addr;
  assign seq_wsel    = wsel_q;
  assign seq_roplen  = oplen_q;
  assign seq_rblen   = blen_q;
  assign seq_viu_fn  = fn_q;
  assign seq_viu_imm = imm_q;

endmodule

// File: doc/vuvxu_banked8_seq.md
# vuvxu_banked8_seq

Issue sequencer directly upstream of bank 0 in the 8-bank vector execution unit. Accepts one vector instruction at a time over a valid/ready handshake and emits one read/ALU command per stripe into the bank chain, where a stripe covers up to 8 elements, one per bank. It also emits the matching write command a fixed number of cycles later. Each bank forwards and decrements the per-stripe counts, so the sequencer only drives bank 0.

## Interface
- NBANK, 8, banks in the chain; stripe width
- REGW, 8, bank register address width (wraps modulo 2^REGW)
- VLENW, 11, vector length / utidx width
- FNW, 11, VIU function field width
- DATAW, 65, datapath width
- OPLW, 2, operand-latch enable width
- RPW, 8, read-port bank-latch width
- WPW, 3, write-select width
- WLAT, 2, read-to-write command delay in cycles (≥1)
- clk  in  1  clock; one clock
- reset  in  1  asynchronous, active-high
- in_val  in  1  command valid
- in_rdy  out  1  command accepted when in_val&in_rdy at clk edge
- in_vlen  in  VLENW  element count (0 = no-op)
- in_rs  in  REGW  source register base
- in_rd  in  REGW  destination register base
- in_oplen  in  OPLW  operand-latch enables, passed through
- in_blen  in  RPW  bank-latch enables, passed through
- in_wsel  in  WPW  writeback select, passed through
- in_viu  in  1  command uses the VIU (else read/write only)
- in_fn  in  FNW  VIU function
- in_imm  in  DATAW  immediate
- seq_ren, seq_rlast  out  1 each  read enable / final stripe
- seq_rcnt  out  3  banks beyond bank 0 in this stripe
- seq_raddr  out  REGW  read address
- seq_roplen  out  OPLW; seq_rblen out RPW  latched fields
- seq_viu_val  out  1; seq_viu_fn out FNW; seq_viu_utidx out VLENW; seq_viu_imm out DATAW
- seq_wen, seq_wlast  out  1 each; seq_wcnt out 3; seq_waddr out REGW; seq_wsel out WPW
- done  out  1  one-cycle pulse at instruction completion

## Operation
- FSM: IDLE, ISSUE, DRAIN. in_rdy = (state==IDLE). All seq_* outputs are registered.
- IDLE + accept with vlen≠0: latch all fields; rem←vlen; k←0; go to ISSUE.
- IDLE + accept with vlen=0: go to DRAIN with an empty write pipe. done pulses on the next cycle; no enables are asserted.
- Each ISSUE cycle drives stripe k:
  - ren=1; rcnt=min(rem,NBANK)−1; raddr=rs+k (mod 2^REGW).
  - viu_val=in_viu; viu_utidx=NBANK·k (mod 2^VLENW).
  - rlast=1 iff rem≤NBANK.
  - Then rem−=min(rem,NBANK) and k++.
- After the stripe with rlast, go to DRAIN.
- Write side is a WLAT-deep shift register of {wen, wlast, wcnt, waddr=rd+k}. Each entry is loaded in the same cycle as its read and emerges exactly WLAT cycles later.
- DRAIN: done=1 in the cycle seq_wen&seq_wlast is driven. The FSM enters IDLE on the next edge.
- fn, imm, roplen, rblen and wsel hold their latched values while not IDLE. When enables are low, these fields and addr/cnt are don't-care, but the bench checks them only when qualified.
- No backpressure from the bank chain; the sequencer never stalls once in ISSUE.
- Async reset, including mid-instruction:
  - state=IDLE; in_rdy=1.
  - All enables, rlast, wlast and done go to 0; all counts, addresses, utidx, fn and imm go to 0.
  - The write shift register is cleared, so pending writes are dropped.

## Timing
- Accept at edge T. Stripe k read appears at T+1+k; its write appears at T+1+k+WLAT.
- Number of stripes N=ceil(vlen/8). Reads occupy T+1..T+N; done is at T+N+WLAT. The next accept is possible at edge T+N+WLAT+1.
- vlen=0: done at T+1; next accept at T+2.
- A stripe's write fields match its read fields exactly (cnt, last), shifted by WLAT.
- rem arithmetic is VLENW-wide unsigned. The maximum vlen 2^VLENW−1 must complete without overflow.

## Test plan
- vlen=8, rs=4, rd=9, WLAT=2, accept at T -> at T+1: ren=1, rcnt=7, raddr=4, rlast=1, utidx=0. At T+3: wen=1, wcnt=7, waddr=9, wlast=1, done=1. in_rdy=1 at T+4.
- vlen=20, in_viu=1 -> stripes at T+1..T+3 with rcnt 7,7,3; raddr rs,rs+1,rs+2; utidx 0,8,16; rlast only on the third stripe.
- vlen=0 -> no ren/wen ever; done at T+1; a second command with vlen=1 is accepted at T+2 and gives rcnt=0, rlast=1.
- rs=254, rd=255, vlen=24 -> raddr 254,255,0 and waddr 255,0,1 (wrap).
- Assert reset at T+2 of a vlen=64 instruction -> all outputs 0 at once. in_rdy=1 after release, and no residual wen ever follows.
- in_val held high continuously over three commands -> each is accepted exactly at the cycle after the previous done; there is no overlap of rlast/wlast between instructions.
